seq_magnitude_comparator: RTL and testbench



---
 rtl/seq_magnitude_comparator_pkg.sv | 30 +++
 rtl/seq_magnitude_comparator_cmp_chunk.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 125 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, running
// decision encoding and the decision-to-{e,g,l} mapping.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } decision_t;

    // Returns {e, g, l}; exactly one bit is set for any legal decision.
    function automatic logic [2:0] decision_onehot(input decision_t d);
        logic [2:0] egl;
        egl = 3'b100;
        case (d)
            EQ:      egl = 3'b100;
            GT:      egl = 3'b010;
            LT:      egl = 3'b001;
            default: egl = 3'b100;
        endcase
        return egl;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp_chunk.sv
// Combinational unsigned comparator for one DIGIT-bit slice of the operands.
module cmp_chunk #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = (a_i == b_i);
    assign gt = (a_i >  b_i);
    assign lt = (a_i <  b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock.
// Optional macro SEQ_CMP_EARLY_EXIT_EN ends the scan at the first differing chunk.
module seq_magnitude_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic             e,
    output logic             g,
    output logic             l
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_magnitude_comparator: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    state_t           state_q, state_d;
    decision_t        dec_q, dec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;
    logic [2:0]       egl_q, egl_d;

    logic [DIGIT-1:0] chunk_a, chunk_b;
    logic             chunk_eq, chunk_gt, chunk_lt;
    logic             finish;

    assign chunk_a = a_q[int'(idx_q)*DIGIT +: DIGIT];
    assign chunk_b = b_q[int'(idx_q)*DIGIT +: DIGIT];

    cmp_chunk #(.DIGIT(DIGIT)) u_cmp_chunk (
        .a_i (chunk_a),
        .b_i (chunk_b),
        .eq  (chunk_eq),
        .gt  (chunk_gt),
        .lt  (chunk_lt)
    );

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = 1'b0;
        egl_d   = egl_q;
        finish  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Flipping both MSBs maps two's complement onto offset binary,
                    // so the unsigned chunk compare yields the signed order.
                    a_d     = a ^ (signed_mode ? MSB_MASK : '0);
                    b_d     = b ^ (signed_mode ? MSB_MASK : '0);
                    idx_d   = IDX_W'(NCHUNK - 1);
                    dec_d   = EQ;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (dec_q == EQ && !chunk_eq) begin
                    dec_d = chunk_gt ? GT : (chunk_lt ? LT : EQ);
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    finish = 1'b1;
`endif
                end
                if (idx_q == '0) begin
                    finish = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
                if (finish) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    egl_d   = decision_onehot(dec_d);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dec_q   <= EQ;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            egl_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            egl_q   <= egl_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign valid       = valid_q;
    assign {e, g, l}   = egl_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed self-checking bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2).
module tb_seq_magnitude_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, valid, e, g, l;

    int tests = 0;
    int fails = 0;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .valid       (valid),
        .e           (e),
        .g           (g),
        .l           (l)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge (edge 1).
    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic sm);
        start = 1'b1; a = av; b = bv; signed_mode = sm;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges since the accepting edge until valid is seen.
    task automatic wait_valid(input int from, output int edges);
        edges = from;
        while (!valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm, input int exp_lat, input logic [2:0] exp_egl);
        int ed;
        launch(av, bv, sm);
        wait_valid(1, ed);
        check({tag, " latency"}, ed, exp_lat);
        check({tag, " egl"}, {e, g, l}, exp_egl);
        $display("[TB] op %s a=%02h b=%02h s=%0d -> edges=%0d egl=%b", tag, av, bv, sm, ed, {e, g, l});
        @(posedge clk);
        @(negedge clk);
        check({tag, " pulse"}, {valid, busy}, 2'b00);
        check({tag, " held"}, {e, g, l}, exp_egl);
    endtask

    initial begin
        int ed;
        int vcount;

        @(negedge clk);
        @(negedge clk);
        check("reset outputs", {busy, valid, e, g, l}, 5'b00000);
        rst = 1'b0;

        do_op("eq_5A", 8'h5A, 8'h5A, 1'b0, 5, 3'b100);
        do_op("u_C3_3C", 8'hC3, 8'h3C, 1'b0, EE ? 2 : 5, 3'b010);
        do_op("s_C3_3C", 8'hC3, 8'h3C, 1'b1, EE ? 2 : 5, 3'b001);
        do_op("s_80_7F", 8'h80, 8'h7F, 1'b1, EE ? 2 : 5, 3'b001);
        do_op("u_80_7F", 8'h80, 8'h7F, 1'b0, EE ? 2 : 5, 3'b010);
        do_op("s_FF_FE", 8'hFF, 8'hFE, 1'b1, 5, 3'b010);

        // start while RUN must be dropped
        launch(8'h10, 8'h20, 1'b0);
        check("busy in run", busy, 1'b1);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_valid(2, ed);
        check("run_start latency", ed, EE ? 3 : 5);
        check("run_start egl", {e, g, l}, 3'b001);
        $display("[TB] op run_start a=10 b=20 (FF/00 injected) -> edges=%0d egl=%b", ed, {e, g, l});
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) vcount++;
        end
        check("run_start dropped", vcount, 0);
        check("run_start idle", {busy, e, g, l}, 4'b0001);

        // reset in the second RUN cycle aborts the operation
        launch(8'h33, 8'h33, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("busy run2", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort outputs", {busy, valid, e, g, l}, 5'b00000);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) vcount++;
        end
        check("abort no valid", vcount, 0);
        $display("[TB] op abort a=33 b=33 -> valids=%0d egl=%b", vcount, {e, g, l});

        do_op("u_80_00", 8'h80, 8'h00, 1'b0, EE ? 2 : 5, 3'b010);

        // back-to-back: restart in the DONE cycle
        launch(8'h5A, 8'h5A, 1'b0);
        wait_valid(1, ed);
        check("b2b first latency", ed, 5);
        check("b2b first egl", {e, g, l}, 3'b100);
        launch(8'h01, 8'h02, 1'b0);
        wait_valid(1, ed);
        check("b2b second spacing", ed, 5);
        check("b2b second egl", {e, g, l}, 3'b001);
        $display("[TB] op b2b a=01 b=02 -> spacing=%0d egl=%b", ed, {e, g, l});
        @(posedge clk);
        @(negedge clk);
        check("b2b pulse", valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
